// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: sequencer for a single-MAC, time-multiplexed FIR filter.
// After reset the delay line is zero-filled. Then each accepted sample is
// written to a circular delay-line RAM, followed by a sweep over all taps that
// drives the ROM/RAM read addresses and the accumulator controls.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   sample_valid   new input sample this cycle (1-cycle pulse)
//   busy           controller not in IDLE
//   wr_en, wr_zero delay-line write strobe / force written data to zero
//   wr_addr        delay-line write address
//   rd_en          delay-line and coefficient ROM read strobe
//   coef_addr      coefficient ROM address (tap index k)
//   tap_addr       delay-line read address, (base - k) mod Num_coef
//   acc_clr        accumulator loads the product instead of adding it
//   acc_en         accumulator update enable (rd_en delayed by read latency)
//   out_valid      accumulator holds the finished output (1-cycle pulse)
//   overrun        a sample arrived while busy and was dropped (1-cycle pulse)
module fir_serial_ctrl #(
  parameter int Num_coef = 17,
  localparam int AW = (Num_coef > 1) ? $clog2(Num_coef) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  output logic          busy,
  output logic          wr_en,
  output logic          wr_zero,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] coef_addr,
  output logic [AW-1:0] tap_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_valid,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST = AW'(Num_coef - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state,       state_d;
  logic [AW-1:0] wr_ptr,      wr_ptr_d;
  logic          busy_q,      busy_d;
  logic          wr_en_q,     wr_en_d;
  logic          wr_zero_q,   wr_zero_d;
  logic [AW-1:0] wr_addr_q,   wr_addr_d;
  logic          rd_en_q,     rd_en_d;
  logic [AW-1:0] coef_q,      coef_d;
  logic [AW-1:0] tap_q,       tap_d;
  logic          acc_clr_q,   acc_clr_d;
  logic          acc_en_q,    acc_en_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q,   overrun_d;

  logic accept;

  assign accept = (state == S_IDLE) && sample_valid;

  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_zero_d   = 1'b0;
    wr_addr_d   = '0;
    rd_en_d     = rd_en_q;
    coef_d      = coef_q;
    tap_d       = tap_q;
    // Accumulator strobes trail the read strobe by the one-cycle read latency.
    acc_en_d    = rd_en_q;
    acc_clr_d   = rd_en_q && (coef_q == '0);
    out_valid_d = 1'b0;
    overrun_d   = sample_valid && (state != S_IDLE);

    unique case (state)
      S_INIT: begin
        busy_d = 1'b1;
        // The registered write strobe doubles as the sweep-in-progress flag,
        // so the sweep restarts from address 0 whenever reset clears it.
        if (wr_en_q && (wr_addr_q == LAST)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_zero_d = 1'b1;
          wr_addr_d = wr_en_q ? (wr_addr_q + AW'(1)) : '0;
        end
      end

      S_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          rd_en_d  = 1'b1;
          coef_d   = '0;
          tap_d    = wr_ptr;
          wr_ptr_d = (wr_ptr == LAST) ? '0 : (wr_ptr + AW'(1));
        end
      end

      S_RUN: begin
        if (coef_q == LAST) begin
          state_d = S_FLUSH;
          rd_en_d = 1'b0;
          coef_d  = '0;
          tap_d   = '0;
        end else begin
          coef_d = coef_q + AW'(1);
          tap_d  = (tap_q == '0) ? LAST : (tap_q - AW'(1));
        end
      end

      S_FLUSH: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      wr_ptr      <= '0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_zero_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      coef_q      <= '0;
      tap_q       <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_zero_q   <= wr_zero_d;
      wr_addr_q   <= wr_addr_d;
      rd_en_q     <= rd_en_d;
      coef_q      <= coef_d;
      tap_q       <= tap_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // The sample write in IDLE is the only combinational path to the outputs.
  assign wr_en     = wr_en_q | accept;
  assign wr_zero   = wr_zero_q;
  assign wr_addr   = accept ? wr_ptr : wr_addr_q;
  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign coef_addr = coef_q;
  assign tap_addr  = tap_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
module tb_fir_serial_ctrl;

  localparam int N  = 17;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic          busy;
  logic          wr_en;
  logic          wr_zero;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] coef_addr;
  logic [AW-1:0] tap_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_valid;
  logic          overrun;

  fir_serial_ctrl #(.Num_coef(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_zero     (wr_zero),
    .wr_addr     (wr_addr),
    .rd_en       (rd_en),
    .coef_addr   (coef_addr),
    .tap_addr    (tap_addr),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic          busy;
    logic          wr_en;
    logic          wr_zero;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] coef_addr;
    logic [AW-1:0] tap_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          out_valid;
    logic          overrun;
  } outs_t;

  typedef struct packed {
    logic  sv;
    outs_t exp;
  } vec_t;

  // Addresses are don't-care while their strobe is expected low.
  function automatic outs_t masked(outs_t o, outs_t e);
    outs_t r = o;
    if (!e.wr_en) begin
      r.wr_zero = 1'b0;
      r.wr_addr = '0;
    end
    if (!e.rd_en) begin
      r.coef_addr = '0;
      r.tap_addr  = '0;
    end
    return r;
  endfunction

  task automatic check_outs(input string name, input outs_t e);
    outs_t a;
    a.busy      = busy;
    a.wr_en     = wr_en;
    a.wr_zero   = wr_zero;
    a.wr_addr   = wr_addr;
    a.rd_en     = rd_en;
    a.coef_addr = coef_addr;
    a.tap_addr  = tap_addr;
    a.acc_clr   = acc_clr;
    a.acc_en    = acc_en;
    a.out_valid = out_valid;
    a.overrun   = overrun;
    total_cnt++;
    if (masked(a, e) == masked(e, e))
      pass_cnt++;
    else
      $display("FAIL %s: got %h expected %h (busy,wr_en,wr_zero,wr_addr,rd_en,coef,tap,clr,acc_en,ov,overrun)",
               name, masked(a, e), masked(e, e));
  endtask

  // Cycle c after reset release during the zero-fill sweep.
  function automatic outs_t exp_init(int c);
    outs_t e = '0;
    if (c >= 1 && c <= N) begin
      e.busy    = 1'b1;
      e.wr_en   = 1'b1;
      e.wr_zero = 1'b1;
      e.wr_addr = AW'(c - 1);
    end
    return e;
  endfunction

  // Cycle d relative to an accepted sample written at address base;
  // ov_at > 0 marks an extra (dropped) sample_valid at that offset.
  function automatic outs_t exp_at(int d, int base, int ov_at);
    outs_t e = '0;
    if (d == 0) begin
      e.wr_en   = 1'b1;
      e.wr_addr = AW'(base);
    end
    if (d >= 1 && d <= N + 2) e.busy = 1'b1;
    if (d >= 1 && d <= N) begin
      e.rd_en     = 1'b1;
      e.coef_addr = AW'(d - 1);
      e.tap_addr  = AW'((base - (d - 1) + N) % N);
    end
    if (d >= 2 && d <= N + 1) e.acc_en = 1'b1;
    if (d == 2) e.acc_clr = 1'b1;
    if (d == N + 2) e.out_valid = 1'b1;
    if (ov_at > 0 && d == ov_at + 1) e.overrun = 1'b1;
    return e;
  endfunction

  // Entered and left at posedge+1.
  task automatic do_init(input string tag);
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    for (int c = 0; c <= N + 1; c++) begin
      #2;
      check_outs($sformatf("%s c=%0d", tag, c), exp_init(c));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int base, input int len, input int ov_at, input string tag);
    vec_t tbl[$];
    for (int d = 0; d < len; d++) begin
      vec_t v;
      v.sv  = (d == 0) || (ov_at > 0 && d == ov_at);
      v.exp = exp_at(d, base, ov_at);
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      sample_valid = tbl[i].sv;
      #2;
      check_outs($sformatf("%s b=%0d d=%0d", tag, base, i), tbl[i].exp);
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    #2;
    check_outs("reset", '0);
    @(posedge clk);
    #1;
    do_init("init1");

    // Single sample, then stay idle a little.
    run_frame(0, N + 5, 0, "single");

    // Reset asserted mid-RUN, 8 cycles into the computation.
    run_frame(1, 8, 0, "midrun");
    #2;
    check_outs("midrun d=8", exp_at(8, 1, 0));
    rst_n = 1'b0;
    #1;
    check_outs("midrun async reset", '0);
    @(posedge clk);
    #1;
    check_outs("midrun held reset", '0);
    @(posedge clk);
    #1;
    do_init("init2");

    // Dropped sample during RUN; next accepted sample takes the next address.
    run_frame(0, N + 3, 5, "overrun");
    run_frame(1, N + 3, 0, "after_ov");

    // Period N+2: second pulse lands in DONE and is dropped.
    run_frame(2, N + 2, 0, "p19");
    sample_valid = 1'b1;
    #2;
    check_outs("p19 done-sample", exp_at(N + 2, 2, 0));
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    #2;
    e = '0;
    e.overrun = 1'b1;
    check_outs("p19 overrun", e);
    @(posedge clk);
    #1;
    run_frame(3, N + 3, 0, "p19 next");

    // Fresh pointer, then N+1 samples back-to-back at the minimum period.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_init("init3");
    for (int s = 0; s <= N; s++)
      run_frame(s % N, N + 3, 0, "b2b");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
- Sequencer for a time-multiplexed (single-MAC) FIR filter.
- On each accepted input sample it:
  - writes the sample into a circular delay-line RAM;
  - sweeps the coefficient ROM address and the delay-line read address over all taps;
  - drives the MAC accumulator controls and flags the finished output.
- Sits between the sample source, the coefficient ROM (1-cycle synchronous read), the delay-line RAM (1-cycle synchronous read) and the MAC/accumulator.

Parameters:
- Num_coef, 17, number of taps. Equals ROM depth and delay-line depth. Need not be a power of 2.
- AW, log2(Num_coef) (ceil), address width. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  new input sample present this cycle (1-cycle pulse)
- busy  out  1  controller not in IDLE
- wr_en  out  1  delay-line write strobe
- wr_zero  out  1  force written data to zero (init sweep)
- wr_addr  out  AW  delay-line write address
- rd_en  out  1  delay-line and ROM read strobe
- coef_addr  out  AW  coefficient ROM address
- tap_addr  out  AW  delay-line read address
- acc_clr  out  1  accumulator loads product instead of adding
- acc_en  out  1  accumulator update enable
- out_valid  out  1  accumulator holds finished output (1-cycle pulse)
- overrun  out  1  sample dropped (1-cycle pulse)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=INIT; all outputs 0; wr_ptr=0; k=0.
  - Reset mid-operation abandons the computation. No out_valid is issued. Init restarts on release.
- INIT:
  - N cycles with wr_en=1, wr_zero=1, wr_addr=0..N-1. Zero-fills the delay line.
  - Then IDLE with wr_ptr=0. busy=1 throughout.
- IDLE (busy=0), on sample_valid=1:
  - Same cycle, combinationally: wr_en=1, wr_zero=0, wr_addr=wr_ptr.
  - Next edge: base<=wr_ptr; wr_ptr<=(wr_ptr==N-1)?0:wr_ptr+1; k<=0; go to RUN.
- RUN (N cycles, k=0..N-1):
  - rd_en=1; coef_addr=k; tap_addr=(base-k) mod N.
  - tap_addr is implemented as a down-counter from base that wraps 0->N-1 (no modulo arithmetic).
  - After k=N-1, go to FLUSH.
- Accumulator timing:
  - acc_en is rd_en delayed 1 cycle to match ROM/RAM read latency.
  - acc_clr=1 only in the cycle of acc_en for k=0.
- FLUSH (1 cycle): acc_en=1 for tap N-1. Then DONE.
- DONE (1 cycle): out_valid=1. Then IDLE.
- Latency:
  - sample_valid at cycle t -> RUN t+1..t+N -> FLUSH t+N+1 -> out_valid t+N+2.
  - Minimum sample period: N+3 cycles.
- Overrun:
  - sample_valid in any state other than IDLE (including INIT and DONE): sample ignored, no write, wr_ptr unchanged.
  - overrun=1 in the following cycle, for 1 cycle. The current computation is unaffected.
- Registers: all outputs except wr_en/wr_zero/wr_addr in IDLE are registered.
- Exclusivity:
  - rd_en and wr_en are never high in the same cycle.
  - acc_en never high outside the N cycles following the first rd_en.

Test Plan:
- Reset release, N=17 -> wr_en=wr_zero=1 for exactly 17 cycles, wr_addr 0..16. busy falls on cycle 18 after release. No other strobes.
- Single sample_valid in IDLE at cycle t (wr_ptr=0):
  - wr_addr=0 at t.
  - coef_addr 0..16 and tap_addr 0,16,15,...,1 over t+1..t+17.
  - acc_en t+2..t+18; acc_clr only at t+2.
  - out_valid only at t+19.
- 18 samples at period 20:
  - wr_addr sequence 0..16,0.
  - 18th computation has base=0; 17th has tap_addr 16,15,...,0.
- sample_valid at t+5 during RUN -> overrun=1 at t+6 only, no wr_en. out_valid still at t+19. Next accepted sample uses wr_addr=1.
- Back-to-back at period 20 (N+3) -> every sample accepted, never overrun. Same pulse with period 19 (sample during DONE) -> overrun.
- rst_n low at t+8 mid-RUN -> all outputs 0 immediately. No out_valid. INIT sweep repeats after release. wr_ptr=0 on the next sample.
